// File: rtl/pin_entry_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pin_entry_collector_if                                    |
// | Purpose  : Keypad-side inputs and PIN-side outputs of the collector. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface pin_entry_collector_if;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    logic       try_psswrd;
    logic [7:0] psswrd_atmpt;
    logic [1:0] digit_count;
    logic       entry_err;

    modport master (
        output enable, key_valid, key_code,
        input  try_psswrd, psswrd_atmpt, digit_count, entry_err
    );

    modport slave (
        input  enable, key_valid, key_code,
        output try_psswrd, psswrd_atmpt, digit_count, entry_err
    );
endinterface
`default_nettype wire

// File: rtl/pin_entry_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pin_entry_collector                                       |
// | Purpose  : Collects a two-digit keypad PIN and submits it as binary. |
// |            Optional idle timeout enabled by macro PIN_TIMEOUT_EN.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pin_entry_collector #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMO_W          = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    pin_entry_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_key_q;
    logic [6:0]  r_acc;
    logic        r_try;
    logic        r_err;
    logic [7:0]  r_atmpt;

    logic        w_event;
    logic        w_timeout;
    logic [6:0]  w_acc_next;

    // Counter width must cover the timeout span.
    if ((64'd1 << TMO_W) < 64'(TIMEOUT_CYCLES)) begin : g_tmo_w_check
        $error("TMO_W too small for TIMEOUT_CYCLES");
    end

    assign w_event    = bus.key_valid & ~r_key_q;
    assign w_acc_next = (r_acc * 7'd10) + {3'b000, bus.key_code};

`ifdef PIN_TIMEOUT_EN
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state != ST_IDLE) && (r_tmo_cnt == c_tmo_last) && !w_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!bus.enable || w_event || r_state == ST_IDLE || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            // Loaded high so a key held through reset must be released first.
            r_key_q <= 1'b1;
            r_try   <= 1'b0;
            r_err   <= 1'b0;
            r_atmpt <= '0;
        end else begin
            r_key_q <= bus.key_valid;
            r_try   <= 1'b0;
            r_err   <= 1'b0;
            if (!bus.enable) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
            end else if (w_event) begin
                case (bus.key_code)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                        if (r_state == ST_IDLE) begin
                            r_acc   <= {3'b000, bus.key_code};
                            r_state <= ST_ONE;
                        end else if (r_state == ST_ONE) begin
                            r_acc   <= w_acc_next;
                            r_state <= ST_TWO;
                        end
                    end
                    4'hA: begin
                        r_acc   <= '0;
                        r_state <= ST_IDLE;
                    end
                    4'hB: begin
                        if (r_state == ST_TWO) begin
                            r_atmpt <= {1'b0, r_acc};
                            r_try   <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                        r_acc   <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end else if (w_timeout) begin
                r_acc   <= '0;
                r_state <= ST_IDLE;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.try_psswrd   = r_try;
    assign bus.entry_err    = r_err;
    assign bus.psswrd_atmpt = r_atmpt;
    assign bus.digit_count  = r_state;

endmodule
`default_nettype wire
